// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps key press/release events onto voice slots and writes slot control words to ram.
// Optional feature macro VOICE_STEAL_EN: when defined, a press with no free or matching slot steals the oldest slot.
module voice_allocator #(
   parameter int                NUM_VOICES = 8,
   parameter int                ADDR_W     = 8,
   parameter int                DATA_W     = 32,
   parameter logic [ADDR_W-1:0] VOICE_BASE = 'h10,
   parameter int                AGE_W      = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  evt_valid,
   input  logic [7:0]            evt_keycode,
   input  logic                  evt_is_press,
   output logic                  evt_ready,
   output logic                  ram_req,
   input  logic                  ram_gnt,
   output logic                  ram_wen,
   output logic [ADDR_W-1:0]     ram_waddr,
   output logic [DATA_W-1:0]     ram_din,
   output logic [NUM_VOICES-1:0] active_mask,
   output logic                  overflow
);
   localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE} state_t;

   state_t                r_state, w_next;
   logic [7:0]            r_key_in;
   logic                  r_press;
   logic [IW-1:0]         r_idx, r_target;
   logic                  r_match_vld, r_free_vld, r_old_vld;
   logic [IW-1:0]         r_match_idx, r_free_idx, r_old_idx;
   logic [AGE_W-1:0]      r_old_age;
   logic [NUM_VOICES-1:0] r_mask;
   logic [7:0]            r_keys [NUM_VOICES];
   logic [AGE_W-1:0]      r_ages [NUM_VOICES];

   logic                  w_cur_act, w_m_vld, w_f_vld, w_o_take;
   logic [IW-1:0]         w_m_idx, w_f_idx, w_o_idx, w_tgt;
   logic [AGE_W-1:0]      w_o_age;
   logic                  w_do_write, w_drop, w_last;

   // Running scan results including the slot under inspection this cycle
   always_comb begin
      w_cur_act = r_mask[r_idx];
      w_last    = (r_idx == LAST);
      w_m_vld   = r_match_vld | (w_cur_act & (r_keys[r_idx] == r_key_in));
      w_m_idx   = r_match_vld ? r_match_idx : r_idx;
      w_f_vld   = r_free_vld | ~w_cur_act;
      w_f_idx   = r_free_vld ? r_free_idx : r_idx;
      w_o_take  = w_cur_act & (~r_old_vld | (r_ages[r_idx] > r_old_age));
      w_o_idx   = w_o_take ? r_idx : r_old_idx;
      w_o_age   = w_o_take ? r_ages[r_idx] : r_old_age;

      w_do_write = 1'b0;
      w_drop     = 1'b0;
      w_tgt      = w_m_idx;
      if (w_m_vld) begin
         w_do_write = 1'b1;
      end else if (r_press) begin
         if (w_f_vld) begin
            w_do_write = 1'b1;
            w_tgt      = w_f_idx;
         end else begin
`ifdef VOICE_STEAL_EN
            w_do_write = 1'b1;
            w_tgt      = w_o_idx;
`else
            w_drop     = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (evt_valid) w_next = S_SCAN;
         S_SCAN:  if (w_last) w_next = w_do_write ? S_WRITE : S_IDLE;
         S_WRITE: if (ram_gnt) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      evt_ready = (r_state == S_IDLE);
      ram_req   = (r_state == S_WRITE);
      ram_wen   = (r_state == S_WRITE) & ram_gnt;
      ram_waddr = '0;
      ram_din   = '0;
      overflow  = (r_state == S_SCAN) & w_last & w_drop;
      if (r_state == S_WRITE) begin
         ram_waddr           = VOICE_BASE + ADDR_W'(r_target);
         ram_din[DATA_W-1]   = r_press;
         ram_din[7:0]        = r_key_in;
      end
   end

   assign active_mask = r_mask;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_key_in    <= '0;
         r_press     <= 1'b0;
         r_idx       <= '0;
         r_target    <= '0;
         r_match_vld <= 1'b0;
         r_free_vld  <= 1'b0;
         r_old_vld   <= 1'b0;
         r_match_idx <= '0;
         r_free_idx  <= '0;
         r_old_idx   <= '0;
         r_old_age   <= '0;
         r_mask      <= '0;
         for (int j = 0; j < NUM_VOICES; j++) begin
            r_keys[j] <= '0;
            r_ages[j] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: if (evt_valid) begin
               r_key_in    <= evt_keycode;
               r_press     <= evt_is_press;
               r_idx       <= '0;
               r_match_vld <= 1'b0;
               r_free_vld  <= 1'b0;
               r_old_vld   <= 1'b0;
            end
            S_SCAN: begin
               r_idx       <= r_idx + 1'b1;
               r_match_vld <= w_m_vld;
               r_match_idx <= w_m_idx;
               r_free_vld  <= w_f_vld;
               r_free_idx  <= w_f_idx;
               r_old_vld   <= r_old_vld | w_cur_act;
               r_old_idx   <= w_o_idx;
               r_old_age   <= w_o_age;
               if (w_last) r_target <= w_tgt;
            end
            S_WRITE: if (ram_gnt) begin
               // Slot state only moves on the cycle the write actually lands
               for (int j = 0; j < NUM_VOICES; j++) begin
                  if (IW'(j) == r_target) begin
                     r_mask[j] <= r_press;
                     if (r_press) begin
                        r_keys[j] <= r_key_in;
                        r_ages[j] <= '0;
                     end
                  end else if (r_press && r_mask[j] && (r_ages[j] != '1)) begin
                     r_ages[j] <= r_ages[j] + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with NUM_VOICES=4, VOICE_BASE=8'h10.
module tb_voice_allocator;
   logic        clk = 1'b0;
   logic        reset;
   logic        evt_valid;
   logic [7:0]  evt_keycode;
   logic        evt_is_press;
   logic        evt_ready;
   logic        ram_req;
   logic        ram_gnt;
   logic        ram_wen;
   logic [7:0]  ram_waddr;
   logic [31:0] ram_din;
   logic [3:0]  active_mask;
   logic        overflow;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          wen_k, ovf_k, bad;
   logic [7:0]  w_addr;
   logic [31:0] w_data;

   voice_allocator #(
      .NUM_VOICES(4), .ADDR_W(8), .DATA_W(32), .VOICE_BASE(8'h10), .AGE_W(8)
   ) dut (
      .clk(clk), .reset(reset),
      .evt_valid(evt_valid), .evt_keycode(evt_keycode), .evt_is_press(evt_is_press),
      .evt_ready(evt_ready),
      .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_wen(ram_wen),
      .ram_waddr(ram_waddr), .ram_din(ram_din),
      .active_mask(active_mask), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Issue one event and record the write (cycle after accept, addr, data) and overflow cycle
   task automatic send(input logic [7:0] k, input logic p);
      int guard = 0;
      while (!evt_ready && guard < 50) begin
         tick();
         guard++;
      end
      evt_valid    = 1'b1;
      evt_keycode  = k;
      evt_is_press = p;
      tick();
      evt_valid = 1'b0;
      wen_k  = -1;
      ovf_k  = -1;
      w_addr = '0;
      w_data = '0;
      for (int c = 1; c <= 40; c++) begin
         if (ram_wen) begin
            wen_k  = c;
            w_addr = ram_waddr;
            w_data = ram_din;
         end
         if (overflow) ovf_k = c;
         if (evt_ready) break;
         tick();
      end
      check("return_to_idle", {31'b0, evt_ready}, 32'd1);
   endtask

   initial begin
      reset        = 1'b1;
      evt_valid    = 1'b0;
      evt_keycode  = '0;
      evt_is_press = 1'b0;
      ram_gnt      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_evt_ready", {31'b0, evt_ready}, 32'd1);
      check("rst_ram_req",   {31'b0, ram_req},   32'd0);
      check("rst_ram_wen",   {31'b0, ram_wen},   32'd0);
      check("rst_waddr",     {24'b0, ram_waddr}, 32'd0);
      check("rst_din",       ram_din,            32'd0);
      check("rst_mask",      {28'b0, active_mask}, 32'd0);
      check("rst_overflow",  {31'b0, overflow},  32'd0);
      reset = 1'b0;
      tick();

      // Single press: latency NUM_VOICES+1
      send(8'h15, 1'b1);
      check("t1_latency", wen_k, 32'd5);
      check("t1_waddr", {24'b0, w_addr}, 32'h10);
      check("t1_din", w_data, 32'h8000_0015);
      check("t1_mask", {28'b0, active_mask}, 32'h1);
      check("t1_no_ovf", ovf_k, 32'hFFFF_FFFF);

      // Fill lowest free slots, then release the middle one
      send(8'h1D, 1'b1);
      check("t2_addr_1d", {24'b0, w_addr}, 32'h11);
      send(8'h24, 1'b1);
      check("t2_addr_24", {24'b0, w_addr}, 32'h12);
      check("t2_mask3", {28'b0, active_mask}, 32'h7);
      send(8'h1D, 1'b0);
      check("t2_rel_waddr", {24'b0, w_addr}, 32'h11);
      check("t2_rel_din", w_data, 32'h0000_001D);
      check("t2_rel_mask", {28'b0, active_mask}, 32'h5);

      // Retrigger of a held key reuses its slot
      send(8'h15, 1'b1);
      check("t3_waddr", {24'b0, w_addr}, 32'h10);
      check("t3_din", w_data, 32'h8000_0015);
      check("t3_mask", {28'b0, active_mask}, 32'h5);

      // All slots busy, fifth distinct press
      do_reset();
      send(8'h15, 1'b1);
      send(8'h1D, 1'b1);
      send(8'h24, 1'b1);
      send(8'h2B, 1'b1);
      check("t4_full_mask", {28'b0, active_mask}, 32'hF);
      send(8'h1C, 1'b1);
`ifdef VOICE_STEAL_EN
      check("t4_steal_wen", wen_k, 32'd5);
      check("t4_steal_addr", {24'b0, w_addr}, 32'h10);
      check("t4_steal_din", w_data, 32'h8000_001C);
      check("t4_steal_no_ovf", ovf_k, 32'hFFFF_FFFF);
      check("t4_steal_mask", {28'b0, active_mask}, 32'hF);
      send(8'h15, 1'b0);
      check("t4_stolen_rel_nowrite", wen_k, 32'hFFFF_FFFF);
`else
      check("t4_ovf_cycle", ovf_k, 32'd4);
      check("t4_no_write", wen_k, 32'hFFFF_FFFF);
      check("t4_mask_kept", {28'b0, active_mask}, 32'hF);
      send(8'h2B, 1'b1);
      check("t4_key3_kept", {24'b0, w_addr}, 32'h13);
      send(8'h15, 1'b0);
      check("t4_key0_rel_addr", {24'b0, w_addr}, 32'h10);
      check("t4_key0_rel_din", w_data, 32'h0000_0015);
      check("t4_rel_mask", {28'b0, active_mask}, 32'hE);
`endif

      // Grant withheld for 10 cycles in WRITE
      do_reset();
      ram_gnt      = 1'b0;
      evt_valid    = 1'b1;
      evt_keycode  = 8'h30;
      evt_is_press = 1'b1;
      tick();
      evt_valid = 1'b0;
      check("t5_ready_low_scan", {31'b0, evt_ready}, 32'd0);
      repeat (4) tick();
      bad = 0;
      repeat (10) begin
         if (!(ram_req === 1'b1 && ram_wen === 1'b0 && evt_ready === 1'b0 &&
               ram_waddr === 8'h10 && ram_din === 32'h8000_0030)) bad++;
         tick();
      end
      check("t5_hold_bad_cycles", bad, 32'd0);
      check("t5_mask_before_gnt", {28'b0, active_mask}, 32'h0);
      ram_gnt = 1'b1;
      #1;
      check("t5_wen_on_gnt", {31'b0, ram_wen}, 32'd1);
      tick();
      check("t5_ready_after", {31'b0, evt_ready}, 32'd1);
      check("t5_req_dropped", {31'b0, ram_req}, 32'd0);
      check("t5_mask", {28'b0, active_mask}, 32'h1);

      // Reset asserted while waiting in WRITE
      ram_gnt      = 1'b0;
      evt_valid    = 1'b1;
      evt_keycode  = 8'h40;
      evt_is_press = 1'b1;
      tick();
      evt_valid = 1'b0;
      repeat (4) tick();
      check("t6_in_write", {31'b0, ram_req}, 32'd1);
      reset = 1'b1;
      #1;
      check("t6_req", {31'b0, ram_req}, 32'd0);
      check("t6_wen", {31'b0, ram_wen}, 32'd0);
      check("t6_waddr", {24'b0, ram_waddr}, 32'd0);
      check("t6_din", ram_din, 32'd0);
      check("t6_mask", {28'b0, active_mask}, 32'd0);
      check("t6_ready", {31'b0, evt_ready}, 32'd1);
      ram_gnt = 1'b1;
      bad = 0;
      repeat (3) begin
         if (ram_wen !== 1'b0) bad++;
         tick();
      end
      reset = 1'b0;
      repeat (5) begin
         if (ram_wen !== 1'b0 || evt_ready !== 1'b1) bad++;
         tick();
      end
      check("t6_no_wen_after", bad, 32'd0);
      check("t6_mask_after", {28'b0, active_mask}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
